regfile_sb: RTL and testbench

- Parametrised successor to the core's integer register file.
- Provides NRD combinational read ports, NWR write-back ports, a hardwired zero register and an async-reset register array.
- Integrates a per-register busy scoreboard with an issue handshake, so the decode stage can detect RAW hazards and stall WAW hazards.
- Sits between decode (read and issue side) and write-back (write side).

---
 rtl/regfile_sb_if.sv | 47 ++++
 rtl/regfile_sb.sv | 109 ++++++++++
 tb/tb_regfile_sb.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/write-back bus of the scoreboarded register file.
// master = decode + write-back side, slave = register file.
interface regfile_sb_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned NRD  = 2,
    parameter int unsigned NWR  = 1
);
    // Read side: port i occupies [i*AW +: AW] / [i*XLEN +: XLEN]
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;

    // Issue handshake
    logic                issue_valid;
    logic [AW-1:0]       issue_addr;
    logic                issue_ready;

    // Write-back side: port j occupies [j*AW +: AW] / [j*XLEN +: XLEN]
    logic [NWR-1:0]      wb_we;
    logic [NWR*AW-1:0]   wb_addr;
    logic [NWR*XLEN-1:0] wb_data;

    modport master (
        output rd_addr,
        input  rd_data,
        input  rd_busy,
        output issue_valid,
        output issue_addr,
        input  issue_ready,
        output wb_we,
        output wb_addr,
        output wb_data
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        output rd_busy,
        input  issue_valid,
        input  issue_addr,
        output issue_ready,
        input  wb_we,
        input  wb_addr,
        input  wb_data
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with NRD combinational read ports,
// NWR write-back ports, hardwired zero register and a per-register busy
// scoreboard with an issue handshake (RAW detect / WAW stall).
// Optional macro RF_BYPASS_EN: same-cycle write-back data and busy clear
// are forwarded to the read ports and to issue_ready.
module regfile_sb #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned NRD  = 2,
    parameter int unsigned NWR  = 1
) (
    input  logic        clk,
    input  logic        rst,
    regfile_sb_if.slave bus
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;

    logic [NREG-1:0] w_wb_hit;
    logic [NREG-1:0] w_busy_vis;
    logic [NREG-1:0] w_busy_next;
    logic            w_issue_fire;

    // Registers targeted by an enabled write-back this cycle (never reg 0)
    always_comb begin
        w_wb_hit = '0;
        for (int unsigned j = 0; j < NWR; j++) begin
            if (bus.wb_we[j] && (bus.wb_addr[j*AW +: AW] != '0)) begin
                w_wb_hit[bus.wb_addr[j*AW +: AW]] = 1'b1;
            end
        end
    end

    // Busy vector as seen by the read ports and the issue check
    always_comb begin
`ifdef RF_BYPASS_EN
        w_busy_vis = r_busy & ~w_wb_hit;
`else
        w_busy_vis = r_busy;
`endif
        w_busy_vis[0] = 1'b0;
    end

    assign bus.issue_ready = !bus.issue_valid
                          || (bus.issue_addr == '0)
                          || !w_busy_vis[bus.issue_addr];
    assign w_issue_fire    = bus.issue_valid && bus.issue_ready;

    // Next busy state: write-backs clear, a firing issue sets; set wins
    always_comb begin
        w_busy_next = r_busy & ~w_wb_hit;
        if (w_issue_fire && (bus.issue_addr != '0)) begin
            w_busy_next[bus.issue_addr] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    // Busy scoreboard register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // Register array write; later port index overrides earlier on conflict
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NREG; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < NWR; j++) begin
                if (bus.wb_we[j] && (bus.wb_addr[j*AW +: AW] != '0)) begin
                    r_regs[bus.wb_addr[j*AW +: AW]] <= bus.wb_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_data;

        assign w_addr = bus.rd_addr[gi*AW +: AW];

        // Combinational read; address 0 is hardwired to zero
        always_comb begin
            w_data = (w_addr == '0) ? '0 : r_regs[w_addr];
`ifdef RF_BYPASS_EN
            // Forwarding is suppressed during reset so outputs read zero
            if (!rst && (w_addr != '0)) begin
                for (int unsigned j = 0; j < NWR; j++) begin
                    if (bus.wb_we[j] && (bus.wb_addr[j*AW +: AW] == w_addr)) begin
                        w_data = bus.wb_data[j*XLEN +: XLEN];
                    end
                end
            end
`endif
        end

        assign bus.rd_data[gi*XLEN +: XLEN] = w_data;
        assign bus.rd_busy[gi]              = w_busy_vis[w_addr];
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: table-driven bench for regfile_sb (NRD=2, NWR=2).
// Expectations follow the RF_BYPASS_EN setting of the build.
module tb_regfile_sb;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    regfile_sb_if #(.XLEN(32), .AW(5), .NRD(2), .NWR(2)) bus_if ();

    regfile_sb #(.XLEN(32), .NREG(32), .AW(5), .NRD(2), .NWR(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        iv;
        logic [4:0]  ia;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
        logic [1:0]  e_b;
        logic        e_rdy;
    } vec_t;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  b;
        logic        rdy;
        string       name;
    } exp_t;

    exp_t q[$];
    vec_t tbl[22];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(
        input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
        input logic [4:0] wa1, input logic [31:0] wd1,
        input logic iv, input logic [4:0] ia,
        input logic [4:0] ra0, input logic [4:0] ra1,
        input logic [31:0] e_d0, input logic [31:0] e_d1,
        input logic [1:0] e_b, input logic e_rdy);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.iv = iv; v.ia = ia; v.ra0 = ra0; v.ra1 = ra1;
        v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_b = e_b; v.e_rdy = e_rdy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] d0, input logic [31:0] d1,
                            input logic [1:0] b, input logic rdy, input string nm);
        exp_t e;
        e.d0 = d0; e.d1 = d1; e.b = b; e.rdy = rdy; e.name = nm;
        q.push_back(e);
    endtask

    task automatic compare_pop();
        exp_t e;
        if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
            e = q.pop_front();
            chk({e.name, ".rd_data0"}, bus_if.rd_data[31:0],  e.d0);
            chk({e.name, ".rd_data1"}, bus_if.rd_data[63:32], e.d1);
            chk({e.name, ".rd_busy"},  {30'd0, bus_if.rd_busy}, {30'd0, e.b});
            chk({e.name, ".issue_ready"}, {31'd0, bus_if.issue_ready}, {31'd0, e.rdy});
        end
    endtask

    task automatic drive(input vec_t v);
        bus_if.wb_we       = v.we;
        bus_if.wb_addr     = {v.wa1, v.wa0};
        bus_if.wb_data     = {v.wd1, v.wd0};
        bus_if.issue_valid = v.iv;
        bus_if.issue_addr  = v.ia;
        bus_if.rd_addr     = {v.ra1, v.ra0};
    endtask

    task automatic apply(input vec_t v, input string nm);
        @(negedge clk);
        drive(v);
        push_exp(v.e_d0, v.e_d1, v.e_b, v.e_rdy, nm);
        #2;
        compare_pop();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        drive(mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
                 32'h0, 32'h0, 2'b00, 1'b1));

        // Expected values are the pre-edge outputs for each row
        tbl[0]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 1'b0, 5'd0,  5'd0,  5'd5,
                     32'h0, 32'h0, 2'b00, 1'b1);
        tbl[1]  = mk(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0,  5'd5,  5'd0,
                     BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 2'b00, 1'b1);
        tbl[2]  = mk(2'b01, 5'd0, 32'h12345678, 5'd0, 32'h0, 1'b0, 5'd0,  5'd5,  5'd0,
                     32'hDEADBEEF, 32'h0, 2'b00, 1'b1);
        tbl[3]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 1'b0, 5'd0,  5'd0,  5'd5,
                     32'h0, 32'hDEADBEEF, 2'b00, 1'b1);
        tbl[4]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 1'b1, 5'd7,  5'd7,  5'd5,
                     32'h0, 32'hDEADBEEF, 2'b00, 1'b1);
        tbl[5]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 1'b1, 5'd7,  5'd7,  5'd0,
                     32'h0, 32'h0, 2'b01, 1'b0);
        tbl[6]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 1'b1, 5'd7,  5'd7,  5'd7,
                     32'h0, 32'h0, 2'b11, 1'b0);
        tbl[7]  = mk(2'b01, 5'd7, 32'hA5A5A5A5, 5'd0, 32'h0, 1'b0, 5'd0,  5'd7,  5'd7,
                     BYP ? 32'hA5A5A5A5 : 32'h0, BYP ? 32'hA5A5A5A5 : 32'h0,
                     BYP ? 2'b00 : 2'b11, 1'b1);
        tbl[8]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 1'b1, 5'd7,  5'd7,  5'd0,
                     32'hA5A5A5A5, 32'h0, 2'b00, 1'b1);
        tbl[9]  = mk(2'b01, 5'd7, 32'h77,       5'd0, 32'h0, 1'b0, 5'd0,  5'd7,  5'd3,
                     BYP ? 32'h77 : 32'hA5A5A5A5, 32'h0, BYP ? 2'b00 : 2'b01, 1'b1);
        tbl[10] = mk(2'b01, 5'd3, 32'h33,       5'd0, 32'h0, 1'b1, 5'd3,  5'd3,  5'd7,
                     BYP ? 32'h33 : 32'h0, 32'h77, 2'b00, 1'b1);
        tbl[11] = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 1'b0, 5'd0,  5'd3,  5'd0,
                     32'h33, 32'h0, 2'b01, 1'b1);
        tbl[12] = mk(2'b01, 5'd3, 32'h3C,       5'd0, 32'h0, 1'b1, 5'd3,  5'd3,  5'd0,
                     BYP ? 32'h3C : 32'h33, 32'h0, BYP ? 2'b00 : 2'b01, BYP);
        tbl[13] = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 1'b0, 5'd0,  5'd3,  5'd0,
                     32'h3C, 32'h0, BYP ? 2'b01 : 2'b00, 1'b1);
        tbl[14] = mk(2'b11, 5'd9, 32'h1,        5'd9, 32'h2, 1'b0, 5'd0,  5'd9,  5'd0,
                     BYP ? 32'h2 : 32'h0, 32'h0, 2'b00, 1'b1);
        tbl[15] = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 1'b0, 5'd0,  5'd9,  5'd0,
                     32'h2, 32'h0, 2'b00, 1'b1);
        tbl[16] = mk(2'b01, 5'd4, 32'h55,       5'd0, 32'h0, 1'b0, 5'd0,  5'd4,  5'd4,
                     BYP ? 32'h55 : 32'h0, BYP ? 32'h55 : 32'h0, 2'b00, 1'b1);
        tbl[17] = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 1'b0, 5'd0,  5'd4,  5'd5,
                     32'h55, 32'hDEADBEEF, 2'b00, 1'b1);
        tbl[18] = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 1'b1, 5'd12, 5'd0,  5'd0,
                     32'h0, 32'h0, 2'b00, 1'b1);
        tbl[19] = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 1'b0, 5'd0,  5'd12, 5'd3,
                     32'h0, 32'h3C, BYP ? 2'b11 : 2'b01, 1'b1);
        tbl[20] = mk(2'b10, 5'd0, 32'h0,        5'd12, 32'hABCD, 1'b0, 5'd0, 5'd12, 5'd0,
                     BYP ? 32'hABCD : 32'h0, 32'h0, BYP ? 2'b00 : 2'b01, 1'b1);
        tbl[21] = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0, 1'b0, 5'd0,  5'd12, 5'd3,
                     32'hABCD, 32'h3C, BYP ? 2'b10 : 2'b00, 1'b1);

        @(negedge clk);
        rst = 1'b0;

        // All addresses read zero and idle after reset
        for (int a = 0; a < 32; a += 2) begin
            apply(mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0,
                     5'(a), 5'(a + 1), 32'h0, 32'h0, 2'b00, 1'b1), "sweep");
        end

        for (int i = 0; i < 22; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Async reset mid-cycle with a pending issue and write
        apply(mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd13, 5'd0, 5'd0,
                 32'h0, 32'h0, 2'b00, 1'b1), "iss13");
        apply(mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd13, 5'd13, 5'd5,
                 32'h0, 32'hDEADBEEF, 2'b01, 1'b0), "busy13");

        @(negedge clk);
        drive(mk(2'b01, 5'd5, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b1, 5'd13, 5'd13, 5'd5,
                 32'h0, 32'h0, 2'b00, 1'b1));
        #1;
        rst = 1'b1;
        push_exp(32'h0, 32'h0, 2'b00, 1'b1, "rst_async");
        #1;
        compare_pop();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd13,
                 32'h0, 32'h0, 2'b00, 1'b1));
        push_exp(32'h0, 32'h0, 2'b00, 1'b1, "rst_discard");
        #2;
        compare_pop();

        apply(mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd13, 5'd4, 5'd9,
                 32'h0, 32'h0, 2'b00, 1'b1), "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
